// File: rtl/game_pkg.sv
// Shared key indices, default frame/debounce constants and counter widths
// used by the input sampling path.
package game_pkg;

   localparam int KEY_IDX_LEFT   = 0;
   localparam int KEY_IDX_RIGHT  = 1;
   localparam int KEY_IDX_ATTACK = 2;
   localparam int NUM_KEYS       = 3;

   localparam int unsigned FRAME_DIV_DEFAULT    = 833333;
   localparam int unsigned DEBOUNCE_CYC_DEFAULT = 500000;

   localparam int FRAME_CNT_W = 24;
   localparam int DEB_CNT_W   = 20;

   typedef logic [NUM_KEYS-1:0] key_vec_t;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer for one active-low button, followed by a stable-count
// debouncer producing an active-high debounced level.
module key_debouncer
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw_n,
   output logic level
);

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYC - 1);

   logic                 sync1_reg;
   logic                 sync2_reg;
   logic                 level_reg;
   logic [DEB_CNT_W-1:0] cnt_reg;
   logic                 pressed;

   assign pressed = ~sync2_reg;
   assign level   = level_reg;

   // Released state is 1 on the active-low synchronizer chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= key_raw_n;
         sync2_reg <= sync1_reg;
         if (pressed == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == DEB_LAST) begin
            level_reg <= pressed;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_frame_sampler.sv
// Debounces three buttons and latches them once per game frame as key commands.
// Define INPUT_ATTACK_EDGE_EN to make KEY_ATTACK a one-frame press edge.
module input_frame_sampler
   import game_pkg::*;
#(
   parameter int unsigned FRAME_DIV    = FRAME_DIV_DEFAULT,
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic [2:0] KEY_RAW_N,
   output logic       FRAME_TICK,
   output logic       FRAME_CLK,
   output logic       KEY_LEFT,
   output logic       KEY_RIGHT,
   output logic       KEY_ATTACK
);

   localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_DIV - 1);
   localparam logic [FRAME_CNT_W-1:0] HALF_PRE   = FRAME_CNT_W'(FRAME_DIV / 2 - 1);

   key_vec_t               level;
   key_vec_t               sticky_reg;
   key_vec_t               sticky_next;
   key_vec_t               sample;
   logic [FRAME_CNT_W-1:0] frame_cnt_reg;
   logic                   frame_clk_reg;
   logic                   frame_tick;
   logic                   key_left_reg;
   logic                   key_right_reg;
   logic                   key_attack_reg;
   logic                   key_attack_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_debouncer #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_key_debouncer (
            .clk       (CLOCK),
            .rst       (RESET),
            .key_raw_n (KEY_RAW_N[gi]),
            .level     (level[gi])
         );
      end
   endgenerate

   assign frame_tick = (frame_cnt_reg == FRAME_LAST);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         frame_cnt_reg <= '0;
         frame_clk_reg <= 1'b0;
      end else begin
         if (frame_tick) begin
            frame_cnt_reg <= '0;
            frame_clk_reg <= 1'b0;
         end else begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (frame_cnt_reg == HALF_PRE) begin
               frame_clk_reg <= 1'b1;
            end
         end
      end
   end

   // Sticky catches presses shorter than a frame; reloading with the current
   // level at the tick keeps a held key alive into the next frame.
   always_comb begin
      sample      = sticky_reg | level;
      sticky_next = frame_tick ? level : (sticky_reg | level);
   end

`ifdef INPUT_ATTACK_EDGE_EN
   logic attack_prev_reg;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         attack_prev_reg <= 1'b0;
      end else if (frame_tick) begin
         attack_prev_reg <= sample[KEY_IDX_ATTACK];
      end
   end

   assign key_attack_next = sample[KEY_IDX_ATTACK] & ~attack_prev_reg;
`else
   assign key_attack_next = sample[KEY_IDX_ATTACK];
`endif

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         sticky_reg     <= '0;
         key_left_reg   <= 1'b0;
         key_right_reg  <= 1'b0;
         key_attack_reg <= 1'b0;
      end else begin
         sticky_reg <= sticky_next;
         if (frame_tick) begin
            // Opposing directions cancel each other out.
            key_left_reg   <= sample[KEY_IDX_LEFT] & ~sample[KEY_IDX_RIGHT];
            key_right_reg  <= sample[KEY_IDX_RIGHT] & ~sample[KEY_IDX_LEFT];
            key_attack_reg <= key_attack_next;
         end
      end
   end

   assign FRAME_TICK = frame_tick;
   assign FRAME_CLK  = frame_clk_reg;
   assign KEY_LEFT   = key_left_reg;
   assign KEY_RIGHT  = key_right_reg;
   assign KEY_ATTACK = key_attack_reg;

endmodule

// File: tb/tb_input_frame_sampler.sv
// Scoreboard bench for input_frame_sampler with FRAME_DIV=20, DEBOUNCE_CYC=4.
module tb_input_frame_sampler;

   localparam int FD = 20;
   localparam int DC = 4;

   typedef struct packed {
      logic l;
      logic r;
      logic a;
   } exp_t;

   typedef enum int {S_IDLE, S_GLITCH, S_SHORT, S_SOCD, S_ATTACK, S_MID} scen_t;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic [2:0] KEY_RAW_N = 3'b111;
   logic       FRAME_TICK;
   logic       FRAME_CLK;
   logic       KEY_LEFT;
   logic       KEY_RIGHT;
   logic       KEY_ATTACK;

   exp_t sb_q[$];
   exp_t cur_exp = '0;
   int   tb_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   pending = 1'b0;
   bit   in_reset = 1'b1;

   input_frame_sampler #(
      .FRAME_DIV    (FD),
      .DEBOUNCE_CYC (DC)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .KEY_RAW_N  (KEY_RAW_N),
      .FRAME_TICK (FRAME_TICK),
      .FRAME_CLK  (FRAME_CLK),
      .KEY_LEFT   (KEY_LEFT),
      .KEY_RIGHT  (KEY_RIGHT),
      .KEY_ATTACK (KEY_ATTACK)
   );

   always #5 CLOCK = ~CLOCK;

   // Cycle index relative to reset release: cycle 0 is the first cycle after release.
   always @(posedge CLOCK) begin
      if (RESET) tb_cyc <= 0;
      else       tb_cyc <= tb_cyc + 1;
   end

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, tb_cyc, act, req);
      end
   endtask

   // Monitor: pops one expected key set per FRAME_TICK and holds it for the frame.
   always @(negedge CLOCK) begin
      if (RESET) begin
         if (!in_reset) check(sb_q.size() == 0, "sb_drain", sb_q.size(), 0);
         in_reset = 1'b1;
         pending  = 1'b0;
         cur_exp  = '0;
         check({KEY_LEFT, KEY_RIGHT, KEY_ATTACK} == 3'b000, "reset_keys",
               int'({KEY_LEFT, KEY_RIGHT, KEY_ATTACK}), 0);
         check(FRAME_CLK == 1'b0, "reset_fclk", int'(FRAME_CLK), 0);
         check(FRAME_TICK == 1'b0, "reset_tick", int'(FRAME_TICK), 0);
      end else begin
         in_reset = 1'b0;
         if (pending) begin
            pending = 1'b0;
            if (sb_q.size() == 0) check(1'b0, "extra_tick", 1, 0);
            else                  cur_exp = sb_q.pop_front();
         end
         check({KEY_LEFT, KEY_RIGHT, KEY_ATTACK} == cur_exp, "keys",
               int'({KEY_LEFT, KEY_RIGHT, KEY_ATTACK}), int'(cur_exp));
         check(FRAME_TICK == ((tb_cyc % FD) == FD - 1), "tick",
               int'(FRAME_TICK), int'((tb_cyc % FD) == FD - 1));
         check(FRAME_CLK == ((tb_cyc % FD) >= FD / 2), "fclk",
               int'(FRAME_CLK), int'((tb_cyc % FD) >= FD / 2));
         if (FRAME_TICK) pending = 1'b1;
      end
   end

   task automatic do_reset();
      RESET     = 1'b1;
      KEY_RAW_N = 3'b111;
      repeat (5) @(posedge CLOCK);
      #1 RESET = 1'b0;
   endtask

   function automatic exp_t mk(input logic l, input logic r, input logic a);
      exp_t e;
      e.l = l;
      e.r = r;
      e.a = a;
      return e;
   endfunction

   // Drives the raw buttons for cycles 0..n-1 of a scenario (bit set = pressed).
   task automatic run_cycles(input int n, input scen_t s);
      logic [2:0] p;
      for (int k = 0; k < n; k++) begin
         p = 3'b000;
         case (s)
            S_GLITCH: p[0] = (k >= 2 && k <= 4);
            S_SHORT:  p[0] = (k >= 2 && k <= 11);
            S_SOCD: begin
               p[0] = (k >= 2);
               p[1] = (k >= 2 && k <= 29);
            end
            S_ATTACK: p[2] = (k >= 2 && k <= 71);
            S_MID:    p[0] = (k >= 2);
            default:  p = 3'b000;
         endcase
         KEY_RAW_N = ~p;
         @(posedge CLOCK);
         #1;
      end
   endtask

   initial begin
      // Idle after reset: ticks at 19 and 39 carry no keys.
      do_reset();
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
      run_cycles(45, S_IDLE);

      // 3-cycle glitch never reaches the debounced level.
      do_reset();
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
      run_cycles(45, S_GLITCH);

      // Press during cycles 2-11 is held by sticky until the tick at 19.
      do_reset();
      sb_q.push_back(mk(1, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
      run_cycles(45, S_SHORT);

      // Both directions cancel; right released at 30 still stickied at 39.
      do_reset();
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(1, 0, 0));
      run_cycles(65, S_SOCD);

      // Attack raw-held cycles 2-71: samples 1 at ticks 19,39,59,79 and 0 at 99.
      do_reset();
`ifdef INPUT_ATTACK_EDGE_EN
      sb_q.push_back(mk(0, 0, 1));
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
      sb_q.push_back(mk(0, 0, 0));
`else
      sb_q.push_back(mk(0, 0, 1));
      sb_q.push_back(mk(0, 0, 1));
      sb_q.push_back(mk(0, 0, 1));
      sb_q.push_back(mk(0, 0, 1));
      sb_q.push_back(mk(0, 0, 0));
`endif
      run_cycles(105, S_ATTACK);

      // Reset at cycle 30 while KEY_LEFT=1 clears it and restarts the frame.
      do_reset();
      sb_q.push_back(mk(1, 0, 0));
      run_cycles(30, S_MID);
      do_reset();
      sb_q.push_back(mk(0, 0, 0));
      run_cycles(25, S_IDLE);

      do_reset();
      repeat (2) @(posedge CLOCK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
